// File: rtl/data_mem_responder.sv
// Word-addressed data memory for the processor load/store port. Every access is
// captured in IDLE, waits LATENCY cycles, then answers with a single-cycle ready pulse.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        capture, finish, req_err;

  logic          cap_rd, cap_wr, cap_err;
  logic [IW-1:0] cap_idx;
  logic [31:0]   cap_wdata;

  logic [31:0] mem [DEPTH];

  always_comb begin
    req_err = (mem_read && mem_write) || (addr[1:0] != 2'b00) ||
              ({2'b00, addr[31:2]} >= 32'(DEPTH));
    state_d = state;
    cnt_d   = cnt;
    capture = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          capture = 1'b1;
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          finish  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response outputs are registered on the edge that enters RESP, so they are
  // high exactly for the RESP cycle and cleared by reset along with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      read_data <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ready     <= finish;
      err       <= finish && cap_err;
      read_data <= (finish && cap_rd && !cap_err) ? mem[cap_idx] : '0;
    end
  end

  // Request fields are latched only at capture; changes during WAIT are ignored.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_rd    <= mem_read;
      cap_wr    <= mem_write;
      cap_err   <= req_err;
      cap_idx   <= addr[IW+1:2];
      cap_wdata <= write_data;
    end
  end

  // Array is not reset; a reset before RESP entry aborts the store.
  always_ff @(posedge clk) begin
    if (!rst && finish && cap_wr && !cap_err)
      mem[cap_idx] <= cap_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: the driver pushes expected responses into a
// queue, and a negedge monitor pops and compares on every ready pulse.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        err;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ready: got ready=1 err=%0b data=%h, required no response",
                   err, read_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (err !== e.err || read_data !== e.data) begin
            miscompares++;
            $display("FAIL %s: got err=%0b data=%h, required err=%0b data=%h",
                     e.name, err, read_data, e.err, e.data);
          end
        end
      end else begin
        vectors++;
        if (err !== 1'b0 || read_data !== 32'h0) begin
          miscompares++;
          $display("FAIL idle_outputs: got err=%0b data=%h, required err=0 data=00000000",
                   err, read_data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the ready cycle with the request dropped.
  // exp_cyc counts posedges from request assertion until ready is observed.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err,
                        input logic [31:0] exp_data, input int exp_cyc, input string name);
    int k;
    sb.push_back('{exp_err, exp_data, name});
    mem_read = rd; mem_write = wr; addr = a; write_data = d;
    k = 0;
    while (k < 50) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (ready) break;
      if (k >= exp_cyc - int'(LAT)) begin
        addr = a ^ 32'h0000_0104;
        write_data = ~d;
      end
    end
    vectors++;
    if (!ready || k != exp_cyc) begin
      miscompares++;
      $display("FAIL %s_timing: got ready=%0b after %0d edges, required ready=1 after %0d edges",
               name, ready, k, exp_cyc);
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int pulses;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    access(0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, LAT + 1, "t1_store");
    idle(1);
    access(1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, LAT + 1, "t2_load");
    idle(1);

    access(0, 1, 32'h20, 32'h11112222, 0, 32'h0, LAT + 1, "t3_prestore");
    idle(1);
    access(1, 1, 32'h20, 32'hFFFFFFFF, 1, 32'h0, LAT + 1, "t3_rd_wr_both");
    idle(1);
    access(1, 0, 32'h20, 32'h0, 0, 32'h11112222, LAT + 1, "t3_reload");
    idle(1);

    access(0, 1, 32'h0, 32'hCAFEF00D, 0, 32'h0, LAT + 1, "t4_prestore");
    idle(1);
    access(1, 0, 32'h13, 32'h0, 1, 32'h0, LAT + 1, "t4_misaligned");
    idle(1);
    access(0, 1, 4 * DEPTH, 32'h0BADBAD0, 1, 32'h0, LAT + 1, "t4_out_of_range");
    idle(1);
    access(1, 0, 4 * DEPTH, 32'h0, 1, 32'h0, LAT + 1, "t4_oor_load");
    idle(1);
    access(1, 0, 32'h0, 32'h0, 0, 32'hCAFEF00D, LAT + 1, "t4_reload");
    idle(1);

    access(0, 1, 32'h40, 32'hA5A5A5A5, 0, 32'h0, LAT + 1, "t5_prestore");
    idle(1);
    mem_write = 1'b1; addr = 32'h40; write_data = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL t5_abort_no_ready: got %0d ready pulses, required 0", pulses);
    end
    access(1, 0, 32'h40, 32'h0, 0, 32'hA5A5A5A5, LAT + 1, "t5_reload");
    idle(1);

    access(0, 1, 32'h3FC, 32'h0F1E2D3C, 0, 32'h0, LAT + 1, "t6_store_last");
    access(1, 0, 32'h3FC, 32'h0, 0, 32'h0F1E2D3C, LAT + 2, "t6_load_b2b");
    idle(1);
    access(1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, LAT + 1, "t6_untouched");

    idle(4);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
